// File: rtl/action_determiner_core_if.sv
// Bundles the phase/step/Q-value inputs and the registered decision outputs
// of action_determiner_core; slave is the core side, master the driver side.
interface action_determiner_core_if;
  logic        [3:0]  step;
  logic        [3:0]  controller;
  logic        [11:0] episode;
  logic signed [15:0] a3st_1;
  logic signed [15:0] a3st_2;
  logic signed [15:0] a3st_3;
  logic signed [15:0] a3st_4;
  logic signed [15:0] a3_1out;
  logic signed [15:0] a3_2out;
  logic signed [15:0] a3_3out;
  logic signed [15:0] a3_4out;
  logic        [1:0]  act;
  logic        [3:0]  st;
  logic        [3:0]  st1;
  logic signed [15:0] Qt;
  logic signed [15:0] maxQt1;

  modport slave (
    input  step, controller, episode,
    input  a3st_1, a3st_2, a3st_3, a3st_4,
    input  a3_1out, a3_2out, a3_3out, a3_4out,
    output act, st, st1, Qt, maxQt1
  );

  modport master (
    output step, controller, episode,
    output a3st_1, a3st_2, a3st_3, a3st_4,
    output a3_1out, a3_2out, a3_3out, a3_4out,
    input  act, st, st1, Qt, maxQt1
  );
endinterface

// File: rtl/action_determiner_core.sv
// Q-learning action selector on a 3x3 grid (SELECT / EVAL / COMMIT phases).
// Define ACTION_EXPLORE_EN for LFSR-driven epsilon-greedy exploration.
module action_determiner_core (
  input logic                      clk,
  input logic                      rst,
  action_determiner_core_if.slave  bus
);
  localparam logic [3:0] GOAL = 4'd8;

  typedef enum logic [3:0] {
    PH_IDLE   = 4'd0,
    PH_SELECT = 4'd1,
    PH_EVAL   = 4'd2,
    PH_COMMIT = 4'd3
  } phase_t;

  phase_t             phase;
  logic        [1:0]  greedy_act;
  logic        [1:0]  sel_act;
  logic signed [15:0] sel_q;
  logic        [3:0]  sel_st1;
  logic signed [15:0] next_max;

  logic        [1:0]  act_r;
  logic        [3:0]  st_r;
  logic        [3:0]  st1_r;
  logic signed [15:0] qt_r;
  logic signed [15:0] max_qt1_r;

  // Grid move; walls leave the state unchanged, illegal states collapse to 0.
  function automatic logic [3:0] move(input logic [3:0] s, input logic [1:0] a);
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] r;
    r = 4'd0;
    if (s > 4'd8) begin
      r = 4'd0;
    end else begin
      if (s >= 4'd6) row = 4'd2;
      else if (s >= 4'd3) row = 4'd1;
      else row = 4'd0;
      col = s - (row * 4'd3);
      case (a)
        2'd0:    r = (row != 4'd0) ? s - 4'd3 : s;
        2'd1:    r = (row != 4'd2) ? s + 4'd3 : s;
        2'd2:    r = (col != 4'd0) ? s - 4'd1 : s;
        2'd3:    r = (col != 4'd2) ? s + 4'd1 : s;
        default: r = s;
      endcase
    end
    return r;
  endfunction

  // Strict '>' keeps the lowest index on ties.
  function automatic logic [1:0] argmax4(
    input logic signed [15:0] q0, input logic signed [15:0] q1,
    input logic signed [15:0] q2, input logic signed [15:0] q3
  );
    logic        [1:0]  bi;
    logic signed [15:0] bv;
    bi = 2'd0;
    bv = q0;
    if (q1 > bv) begin bi = 2'd1; bv = q1; end else begin bi = bi; end
    if (q2 > bv) begin bi = 2'd2; bv = q2; end else begin bi = bi; end
    if (q3 > bv) begin bi = 2'd3; bv = q3; end else begin bi = bi; end
    return bi;
  endfunction

  function automatic logic signed [15:0] max4(
    input logic signed [15:0] q0, input logic signed [15:0] q1,
    input logic signed [15:0] q2, input logic signed [15:0] q3
  );
    logic signed [15:0] m;
    m = q0;
    if (q1 > m) m = q1; else m = m;
    if (q2 > m) m = q2; else m = m;
    if (q3 > m) m = q3; else m = m;
    return m;
  endfunction

  // Decode the phase code; unused codes behave as IDLE.
  always_comb begin
    phase = PH_IDLE;
    case (bus.controller)
      4'd1:    phase = PH_SELECT;
      4'd2:    phase = PH_EVAL;
      4'd3:    phase = PH_COMMIT;
      default: phase = PH_IDLE;
    endcase
  end

  // Greedy choice and the terminal-aware next-state maximum.
  always_comb begin
    greedy_act = argmax4(bus.a3st_1, bus.a3st_2, bus.a3st_3, bus.a3st_4);
    next_max   = max4(bus.a3_1out, bus.a3_2out, bus.a3_3out, bus.a3_4out);
  end

`ifdef ACTION_EXPLORE_EN
  logic [15:0] lfsr_r;
  logic [7:0]  threshold;

  // Fibonacci LFSR, taps 16,14,13,11; free-running every clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  // Epsilon decays linearly with episode down to a floor of 15/256.
  always_comb begin
    threshold = 8'd15;
    if (bus.episode < 12'd240) begin
      threshold = 8'd255 - bus.episode[7:0];
    end else begin
      threshold = 8'd15;
    end
    sel_act = greedy_act;
    if (lfsr_r[7:0] < threshold) begin
      sel_act = lfsr_r[9:8];
    end else begin
      sel_act = greedy_act;
    end
  end
`else
  // Exploration disabled: selection is purely greedy.
  always_comb begin
    sel_act = greedy_act;
  end
`endif

  // Q-value and destination of the chosen action.
  always_comb begin
    sel_q = bus.a3st_1;
    case (sel_act)
      2'd0:    sel_q = bus.a3st_1;
      2'd1:    sel_q = bus.a3st_2;
      2'd2:    sel_q = bus.a3st_3;
      2'd3:    sel_q = bus.a3st_4;
      default: sel_q = bus.a3st_1;
    endcase
    sel_st1 = move(st_r, sel_act);
  end

  // Phase-driven output registers; IDLE holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_r     <= 2'd0;
      st_r      <= 4'd0;
      st1_r     <= 4'd0;
      qt_r      <= 16'sd0;
      max_qt1_r <= 16'sd0;
    end else begin
      case (phase)
        PH_SELECT: begin
          act_r <= sel_act;
          qt_r  <= sel_q;
          st1_r <= sel_st1;
        end
        PH_EVAL: begin
          max_qt1_r <= (st1_r == GOAL) ? 16'sd0 : next_max;
        end
        PH_COMMIT: begin
          st_r <= ((st1_r == GOAL) || (bus.step == 4'd15)) ? 4'd0 : st1_r;
        end
        default: begin
          act_r <= act_r;
        end
      endcase
    end
  end

  assign bus.act    = act_r;
  assign bus.st     = st_r;
  assign bus.st1    = st1_r;
  assign bus.Qt     = qt_r;
  assign bus.maxQt1 = max_qt1_r;
endmodule

// File: tb/tb_action_determiner_core.sv
// Directed self-checking bench for action_determiner_core (greedy build;
// exploration checks compile in when ACTION_EXPLORE_EN is defined).
module tb_action_determiner_core;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  action_determiner_core_if bus ();

  action_determiner_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_q(input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic signed [15:0] c, input logic signed [15:0] d);
    bus.a3st_1 = a; bus.a3st_2 = b; bus.a3st_3 = c; bus.a3st_4 = d;
  endtask

  task automatic set_qn(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c, input logic signed [15:0] d);
    bus.a3_1out = a; bus.a3_2out = b; bus.a3_3out = c; bus.a3_4out = d;
  endtask

  // One phase cycle: controller applied, edge, sample 1 time unit later.
  task automatic run_phase(input logic [3:0] code);
    bus.controller = code;
    @(posedge clk);
    #1;
    bus.controller = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.step = 4'd0; bus.controller = 4'd0; bus.episode = 12'd0;
    set_q(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    set_qn(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    #12;
    total_cnt++; if (bus.act !== 2'd0) $display("FAIL reset_act: got %0d want 0", bus.act); else pass_cnt++;
    total_cnt++; if (bus.st !== 4'd0) $display("FAIL reset_st: got %0d want 0", bus.st); else pass_cnt++;
    total_cnt++; if (bus.st1 !== 4'd0) $display("FAIL reset_st1: got %0d want 0", bus.st1); else pass_cnt++;
    total_cnt++; if (bus.Qt !== 16'sd0) $display("FAIL reset_Qt: got %0d want 0", bus.Qt); else pass_cnt++;
    total_cnt++; if (bus.maxQt1 !== 16'sd0) $display("FAIL reset_maxQt1: got %0d want 0", bus.maxQt1); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_select_wall();
    set_q(16'sd5, -16'sd3, 16'sd100, 16'sd7);
    run_phase(4'd1);
    total_cnt++; if (bus.act !== 2'd2) $display("FAIL wall_act: got %0d want 2", bus.act); else pass_cnt++;
    total_cnt++; if (bus.Qt !== 16'sd100) $display("FAIL wall_Qt: got %0d want 100", bus.Qt); else pass_cnt++;
    total_cnt++; if (bus.st1 !== 4'd0) $display("FAIL wall_st1: got %0d want 0", bus.st1); else pass_cnt++;
  endtask

  task automatic test_moves();
    set_q(16'sd0, 16'sd10, 16'sd0, 16'sd0);
    run_phase(4'd1);
    total_cnt++; if (bus.st1 !== 4'd3) $display("FAIL down_st1: got %0d want 3", bus.st1); else pass_cnt++;
    bus.step = 4'd0;
    run_phase(4'd3);
    total_cnt++; if (bus.st !== 4'd3) $display("FAIL commit_st3: got %0d want 3", bus.st); else pass_cnt++;
    set_q(16'sd0, 16'sd0, 16'sd9, 16'sd0);
    run_phase(4'd1);
    total_cnt++; if (bus.st1 !== 4'd3) $display("FAIL left_wall_st1: got %0d want 3", bus.st1); else pass_cnt++;
    set_q(16'sd0, 16'sd0, 16'sd0, 16'sd10);
    run_phase(4'd1);
    total_cnt++; if (bus.st1 !== 4'd4) $display("FAIL right_st1: got %0d want 4", bus.st1); else pass_cnt++;
    run_phase(4'd3);
    total_cnt++; if (bus.st !== 4'd4) $display("FAIL commit_st4: got %0d want 4", bus.st); else pass_cnt++;
  endtask

  task automatic test_tie();
    set_q(-16'sd1, 16'sd50, 16'sd50, 16'sd2);
    run_phase(4'd1);
    total_cnt++; if (bus.act !== 2'd1) $display("FAIL tie_act: got %0d want 1", bus.act); else pass_cnt++;
    total_cnt++; if (bus.st1 !== 4'd7) $display("FAIL tie_st1: got %0d want 7", bus.st1); else pass_cnt++;
    total_cnt++; if (bus.Qt !== 16'sd50) $display("FAIL tie_Qt: got %0d want 50", bus.Qt); else pass_cnt++;
  endtask

  task automatic test_eval();
    set_q(16'sd0, 16'sd0, 16'sd0, 16'sd10);
    run_phase(4'd1);
    total_cnt++; if (bus.st1 !== 4'd5) $display("FAIL eval_setup_st1: got %0d want 5", bus.st1); else pass_cnt++;
    set_qn(16'sh8000, -16'sd2, -16'sd7, -16'sd1);
    run_phase(4'd2);
    total_cnt++; if (bus.maxQt1 !== -16'sd1) $display("FAIL eval_neg: got %0d want -1", bus.maxQt1); else pass_cnt++;
    set_qn(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000);
    run_phase(4'd2);
    total_cnt++; if (bus.maxQt1 !== 16'sh8000) $display("FAIL eval_min: got %0d want -32768", bus.maxQt1); else pass_cnt++;
    bus.step = 4'd4;
    run_phase(4'd3);
    total_cnt++; if (bus.st !== 4'd5) $display("FAIL commit_st5: got %0d want 5", bus.st); else pass_cnt++;
    set_q(16'sd0, 16'sd9, 16'sd0, 16'sd0);
    run_phase(4'd1);
    total_cnt++; if (bus.st1 !== 4'd8) $display("FAIL goal_st1: got %0d want 8", bus.st1); else pass_cnt++;
    total_cnt++; if (bus.Qt !== 16'sd9) $display("FAIL goal_Qt: got %0d want 9", bus.Qt); else pass_cnt++;
    set_qn(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    run_phase(4'd2);
    total_cnt++; if (bus.maxQt1 !== 16'sd0) $display("FAIL eval_goal: got %0d want 0", bus.maxQt1); else pass_cnt++;
    run_phase(4'd3);
    total_cnt++; if (bus.st !== 4'd0) $display("FAIL commit_goal: got %0d want 0", bus.st); else pass_cnt++;
  endtask

  task automatic test_commit_step15();
    set_q(16'sd0, 16'sd10, 16'sd0, 16'sd0);
    run_phase(4'd1);
    bus.step = 4'd15;
    run_phase(4'd3);
    total_cnt++; if (bus.st !== 4'd0) $display("FAIL commit_step15: got %0d want 0", bus.st); else pass_cnt++;
    bus.step = 4'd4;
    run_phase(4'd3);
    total_cnt++; if (bus.st !== 4'd3) $display("FAIL commit_step4: got %0d want 3", bus.st); else pass_cnt++;
    set_q(16'sd7, 16'sd0, 16'sd0, 16'sd0);
    run_phase(4'd1);
    total_cnt++; if (bus.st1 !== 4'd0) $display("FAIL up_st1: got %0d want 0", bus.st1); else pass_cnt++;
    set_qn(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    run_phase(4'd2);
    total_cnt++; if (bus.maxQt1 !== 16'sd4) $display("FAIL eval_pos: got %0d want 4", bus.maxQt1); else pass_cnt++;
  endtask

  task automatic test_idle_hold();
    set_q(16'sd1, 16'sd900, 16'sd3, 16'sd4);
    set_qn(16'sd500, 16'sd0, 16'sd0, 16'sd0);
    bus.step = 4'd15;
    run_phase(4'd0);
    run_phase(4'd9);
    run_phase(4'd15);
    total_cnt++; if (bus.act !== 2'd0) $display("FAIL idle_act: got %0d want 0", bus.act); else pass_cnt++;
    total_cnt++; if (bus.st !== 4'd3) $display("FAIL idle_st: got %0d want 3", bus.st); else pass_cnt++;
    total_cnt++; if (bus.st1 !== 4'd0) $display("FAIL idle_st1: got %0d want 0", bus.st1); else pass_cnt++;
    total_cnt++; if (bus.Qt !== 16'sd7) $display("FAIL idle_Qt: got %0d want 7", bus.Qt); else pass_cnt++;
    total_cnt++; if (bus.maxQt1 !== 16'sd4) $display("FAIL idle_maxQt1: got %0d want 4", bus.maxQt1); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.controller = 4'd2;
    set_qn(16'sd77, 16'sd0, 16'sd0, 16'sd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.maxQt1 !== 16'sd0) $display("FAIL async_maxQt1: got %0d want 0", bus.maxQt1); else pass_cnt++;
    total_cnt++; if (bus.st !== 4'd0) $display("FAIL async_st: got %0d want 0", bus.st); else pass_cnt++;
    total_cnt++; if (bus.Qt !== 16'sd0) $display("FAIL async_Qt: got %0d want 0", bus.Qt); else pass_cnt++;
    total_cnt++; if (bus.act !== 2'd0) $display("FAIL async_act: got %0d want 0", bus.act); else pass_cnt++;
    bus.controller = 4'd1;
    set_q(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    @(negedge clk);
    rst = 1'b1;
    run_phase(4'd1);
    total_cnt++; if (bus.act !== 2'd3) $display("FAIL post_rst_act: got %0d want 3", bus.act); else pass_cnt++;
    total_cnt++; if (bus.st1 !== 4'd1) $display("FAIL post_rst_st1: got %0d want 1", bus.st1); else pass_cnt++;
    total_cnt++; if (bus.Qt !== 16'sd4) $display("FAIL post_rst_Qt: got %0d want 4", bus.Qt); else pass_cnt++;
  endtask

`ifdef ACTION_EXPLORE_EN
  task automatic test_explore();
    int non_greedy;
    int lfsr_zero;
    non_greedy = 0;
    lfsr_zero  = 0;
    bus.episode = 12'd0;
    set_q(16'sd100, 16'sd0, 16'sd0, 16'sd0);
    for (int i = 0; i < 64; i++) begin
      run_phase(4'd1);
      if (bus.act != 2'd0) non_greedy++;
      if (dut.lfsr_r == 16'd0) lfsr_zero++;
    end
    total_cnt++; if (non_greedy == 0) $display("FAIL explore_ep0: got %0d non-greedy want >0", non_greedy); else pass_cnt++;
    total_cnt++; if (lfsr_zero != 0) $display("FAIL lfsr_zero: got %0d zero states want 0", lfsr_zero); else pass_cnt++;
    non_greedy = 0;
    bus.episode = 12'd4000;
    for (int i = 0; i < 512; i++) begin
      run_phase(4'd1);
      if (bus.act != 2'd0) non_greedy++;
    end
    total_cnt++; if (non_greedy < 3 || non_greedy > 60) $display("FAIL explore_ep4000: got %0d non-greedy want 3..60", non_greedy); else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_select_wall();
    test_moves();
    test_tie();
    test_eval();
    test_commit_step15();
    test_idle_hold();
    test_async_reset();
`ifdef ACTION_EXPLORE_EN
    test_explore();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/action_determiner_core.md
ACTION_DETERMINER_CORE -- requirements
Module: action_determiner

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port step, input, 4 bits: step index within the current episode.
REQ-004 SHALL have port controller, input, 4 bits: phase code (0 IDLE, 1 SELECT, 2 EVAL, 3 COMMIT, 4-15 treated as IDLE).
REQ-005 SHALL have port episode, input, 12 bits: episode count, used for epsilon decay.
REQ-006 SHALL have ports a3st_1..a3st_4, input, signed 16 bits each: Q-values of actions 0..3 for the current state.
REQ-007 SHALL have ports a3_1out..a3_4out, input, signed 16 bits each: Q-values of actions 0..3 for the next state.
REQ-008 SHALL have port act, output, 2 bits: chosen action (0 up, 1 down, 2 left, 3 right).
REQ-009 SHALL have ports st and st1, output, 4 bits each: current state and next state, range 0..8.
REQ-010 SHALL have ports Qt and maxQt1, output, signed 16 bits each: Q(st,act) and max over actions of Q(st1,a).

Function
REQ-011 SHALL model a 3x3 grid: row = st/3, col = st%3; GOAL = 8.
REQ-012 Move rule SHALL be: up gives st-3 if row>0; down gives st+3 if row<2; left gives st-1 if col>0; right gives st+1 if col<2; otherwise the state is unchanged (wall).
REQ-013 SELECT SHALL register, in one cycle, act = selected action, Qt = a3st_(act+1), and st1 = move(st, act).
REQ-014 Greedy choice SHALL be the signed argmax of a3st_1..4, with ties resolved to the lowest index.
REQ-015 EVAL SHALL register maxQt1 = signed max(a3_1out..a3_4out); maxQt1 SHALL be forced to 0 when st1 == GOAL (terminal state).
REQ-016 COMMIT SHALL set st <= 0 if st1 == GOAL or step == 15; otherwise st <= st1.
REQ-017 In IDLE and unused codes, all outputs SHALL hold their values.
REQ-018 Outputs SHALL be registered only: no combinational path from inputs to outputs; each phase has 1-cycle latency.
REQ-019 Comparisons SHALL be full 16-bit two's complement; 0x8000 is the minimum value and SHALL NOT wrap.
REQ-020 A state value outside 0..8 SHALL NOT occur; if it does, move() SHALL return 0.

Reset
REQ-021 While rst is low, asynchronously: act=0, st=0, st1=0, Qt=0, maxQt1=0, LFSR=16'hACE1.
REQ-022 A reset asserted mid-phase SHALL abort that phase; the first post-reset edge SHALL act on the controller value then present.

Configuration
REQ-023 Macro ACTION_EXPLORE_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) SHALL advance every clock.
REQ-024 With ACTION_EXPLORE_EN defined, threshold = (episode < 240) ? 255 - episode : 15; in SELECT, if lfsr[7:0] < threshold then act = lfsr[9:8] (explore), else act is the greedy choice.
REQ-025 Macro ACTION_EXPLORE_EN undefined: LFSR logic SHALL be absent and SELECT SHALL always be greedy.

Verification (ACTION_EXPLORE_EN undefined unless stated)
REQ-026 After reset, st=0, a3st = {5,-3,100,7}, controller=1 -> next edge gives act=2, Qt=100, st1=0 (wall).
REQ-027 st=4, a3st = {-1,50,50,2}, SELECT -> act=1 (tie resolved to lower index), st1=7, Qt=50.
REQ-028 st1=5, a3_out = {0x8000,-2,-7,-1}, EVAL -> maxQt1=-1; with st1=8 -> maxQt1=0.
REQ-029 st1=8, COMMIT -> st=0; st1=3, step=15, COMMIT -> st=0; st1=3, step=4, COMMIT -> st=3.
REQ-030 ACTION_EXPLORE_EN defined, episode=0, 64 SELECTs -> act not always greedy and LFSR never 0; episode=4000 -> explore rate about 6%.
REQ-031 rst pulled low mid-EVAL -> all outputs 0 immediately, without waiting for a clock edge.
